// File: rtl/pwm_modulator.sv
// Center-aligned complementary PWM stage fed by the PI controller.
// Captures the signed control word on each pi_ready rising edge, clamps it to
// a duty count, and loads it into the active duty register at the counter valley.
// A triangle counter compares against the duty to form the reference.
// A dead-time FSM turns that reference into a non-overlapping gate pair.
// The valley also produces a one-cycle sync pulse that triggers the ADC.
module pwm_modulator #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 12,
  parameter int PERIOD     = 2500,
  parameter int DEADTIME   = 50
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] u,
  input  logic                         pi_ready,
  input  logic                         en,
  input  logic                         fault,
  output logic                         pwm_h,
  output logic                         pwm_l,
  output logic                         sync_out,
  output logic [CNT_WIDTH-1:0]         duty_active,
  output logic                         fault_latched
);

  localparam int DT_W = $clog2(DEADTIME + 1);
  localparam logic [CNT_WIDTH-1:0]      PERIOD_C = CNT_WIDTH'(PERIOD);
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);
  localparam logic signed [DATA_WIDTH:0] PERIOD_X = (DATA_WIDTH + 1)'(PERIOD);
  localparam logic [DT_W-1:0]           DT_LOAD  = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0]           DT_ONE   = DT_W'(1);

  typedef enum logic [1:0] {S_OFF, S_DT, S_HON, S_LON} state_t;

  logic                  r_fault_s1, r_fault_s2, r_fault_latched;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_dir_up;
  logic                  r_pi_q;
  logic [CNT_WIDTH-1:0]  r_duty_pend, r_duty_act;
  logic                  r_sync;
  logic                  r_ref_q;
  state_t                r_state;
  logic [DT_W-1:0]       r_dt_cnt;
  logic                  r_pwm_h, r_pwm_l;

  logic signed [DATA_WIDTH:0] w_u_ext;
  logic [CNT_WIDTH-1:0]       w_clamp;
  logic                       w_capture;
  logic                       w_run;
  logic                       w_valley;
  logic                       w_ref;
  logic                       w_force_off;

  // One extra sign bit so that the compare against PERIOD cannot overflow
  assign w_u_ext   = $signed({u[DATA_WIDTH-1], u});
  assign w_capture = pi_ready & ~r_pi_q;
  // The counter stops on the raw synchronised fault as well, so it freezes in
  // the same cycle that the latch is being set.
  assign w_run     = en & ~r_fault_latched & ~r_fault_s2;
  assign w_valley  = (r_cnt == '0);
  // A full-period duty holds the reference high through the peak too
  assign w_ref     = (r_duty_act == PERIOD_C) || (r_cnt < r_duty_act);
  assign w_force_off = r_fault_s2 | r_fault_latched | ~en;

  // Clamp the signed control word into the range 0..PERIOD
  always_comb begin
    w_clamp = w_u_ext[CNT_WIDTH-1:0];
    if (w_u_ext[DATA_WIDTH])
      w_clamp = '0;
    else if (w_u_ext > PERIOD_X)
      w_clamp = PERIOD_C;
  end

  // Two-flop synchroniser for the asynchronous fault input
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fault_s1 <= 1'b0;
      r_fault_s2 <= 1'b0;
    end else begin
      r_fault_s1 <= fault;
      r_fault_s2 <= r_fault_s1;
    end
  end

  // Sticky fault; a set wins over a clear, and a clear needs en low with no fault
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_fault_latched <= 1'b0;
    else if (r_fault_s2)
      r_fault_latched <= 1'b1;
    else if (!en)
      r_fault_latched <= 1'b0;
  end

  // Triangle counter 0..PERIOD..1, parked at 0 counting up while stopped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_dir_up <= 1'b1;
    end else if (!w_run) begin
      r_cnt    <= '0;
      r_dir_up <= 1'b1;
    end else if (r_dir_up) begin
      if (r_cnt == PERIOD_C) begin
        r_cnt    <= PERIOD_C - CNT_ONE;
        r_dir_up <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      if (r_cnt == '0) begin
        r_cnt    <= CNT_ONE;
        r_dir_up <= 1'b1;
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // Valley pulse for the ADC; only emitted while the counter is running
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_sync <= 1'b0;
    else
      r_sync <= w_run & w_valley;
  end

  // pi_ready edge detect; resets high so a level held through reset is ignored
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_pi_q <= 1'b1;
    else
      r_pi_q <= pi_ready;
  end

  // Double buffer: capture into pending, then move to active at the valley.
  // If both happen in one cycle, the active register takes the old pending
  // value and the new capture waits for the next valley.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_duty_pend <= '0;
      r_duty_act  <= '0;
    end else begin
      if (w_capture)
        r_duty_pend <= w_clamp;
      if (w_valley && en)
        r_duty_act <= r_duty_pend;
    end
  end

  // Previous reference value, used to detect a reference change during dead time
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_ref_q <= 1'b0;
    else
      r_ref_q <= w_ref;
  end

  // Dead-time FSM with registered gate outputs; a fault or en low overrides everything
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_OFF;
      r_dt_cnt <= '0;
      r_pwm_h  <= 1'b0;
      r_pwm_l  <= 1'b0;
    end else if (w_force_off) begin
      r_state <= S_OFF;
      r_pwm_h <= 1'b0;
      r_pwm_l <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_state  <= S_DT;
          r_dt_cnt <= DT_LOAD;
          r_pwm_h  <= 1'b0;
          r_pwm_l  <= 1'b0;
        end
        S_DT: begin
          r_pwm_h <= 1'b0;
          r_pwm_l <= 1'b0;
          if (w_ref != r_ref_q) begin
            r_dt_cnt <= DT_LOAD;
          end else if (r_dt_cnt == DT_ONE) begin
            if (w_ref) begin
              r_state <= S_HON;
              r_pwm_h <= 1'b1;
            end else begin
              r_state <= S_LON;
              r_pwm_l <= 1'b1;
            end
          end else begin
            r_dt_cnt <= r_dt_cnt - DT_ONE;
          end
        end
        S_HON: begin
          if (!w_ref) begin
            r_state  <= S_DT;
            r_dt_cnt <= DT_LOAD;
            r_pwm_h  <= 1'b0;
          end else begin
            r_pwm_h <= 1'b1;
          end
          r_pwm_l <= 1'b0;
        end
        S_LON: begin
          if (w_ref) begin
            r_state  <= S_DT;
            r_dt_cnt <= DT_LOAD;
            r_pwm_l  <= 1'b0;
          end else begin
            r_pwm_l <= 1'b1;
          end
          r_pwm_h <= 1'b0;
        end
        default: begin
          r_state <= S_OFF;
          r_pwm_h <= 1'b0;
          r_pwm_l <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_h         = r_pwm_h;
  assign pwm_l         = r_pwm_l;
  assign sync_out      = r_sync;
  assign duty_active   = r_duty_act;
  assign fault_latched = r_fault_latched;

endmodule
